// File: rtl/mult32b_pkg.sv
// Shared types and constants for the two-port M-extension multiplier scheduler.
// Stage structs carry the datapath fields; the tag stays in the top because its width is a module parameter.
package mult32b_pkg;

  localparam int XLEN   = 32;
  localparam int PROD_W = 64;

  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULH   = 2'd1,
    OP_MULHSU = 2'd2,
    OP_MULHU  = 2'd3
  } op_e;

  typedef struct packed {
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            neg;
    op_e             op;
    logic            id;
  } s1_t;

  typedef struct packed {
    logic [PROD_W-1:0] prod;
    logic              neg;
    op_e               op;
    logic              id;
  } s2_t;

  // Two's-complement negate when s is set; 0x80000000 maps to itself.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic s);
    return s ? ((~v) + XLEN'(1)) : v;
  endfunction

endpackage

// File: rtl/mult32b_core.sv
// Combinational 32x32 unsigned multiplier: shifted partial products folded through
// carry-save compressor rows, then one final 64-bit carry-propagate add.
module mult32b_core
  import mult32b_pkg::*;
(
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [PROD_W-1:0] prod
);

  logic [PROD_W-1:0] pp [XLEN];
  logic [PROD_W-1:0] sum_vec;
  logic [PROD_W-1:0] carry_vec;
  logic [PROD_W-1:0] sum_next;
  logic [PROD_W-1:0] carry_next;

  generate
    for (genvar gi = 0; gi < XLEN; gi++) begin : g_pp
      assign pp[gi] = b[gi] ? (PROD_W'(a) << gi) : '0;
    end
  endgenerate

  // Each row is a 3:2 compressor; bits carried past bit 63 are dropped since the product fits in 64.
  always_comb begin
    sum_vec    = '0;
    carry_vec  = '0;
    sum_next   = '0;
    carry_next = '0;
    for (int i = 0; i < XLEN; i++) begin
      sum_next   = sum_vec ^ carry_vec ^ pp[i];
      carry_next = ((sum_vec & carry_vec) | (sum_vec & pp[i]) | (carry_vec & pp[i])) << 1;
      sum_vec    = sum_next;
      carry_vec  = carry_next;
    end
    prod = sum_vec + carry_vec;
  end

endmodule

// File: rtl/mult32b_sched.sv
// Round-robin two-port front end for the shared multiplier tree: sign handling into
// magnitudes, accept register S1, product register S2, signed fix-up on the way out.
module mult32b_sched
  import mult32b_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [1:0]                  req_valid,
  output logic [1:0]                  req_ready,
  input  logic [1:0][1:0]             req_op,
  input  logic [1:0][XLEN-1:0]        req_a,
  input  logic [1:0][XLEN-1:0]        req_b,
  input  logic [1:0][TAG_W-1:0]       req_tag,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic                        resp_id,
  output logic [TAG_W-1:0]            resp_tag,
  output logic [XLEN-1:0]             resp_data
);

  logic             rr_ptr_reg;
  logic             s1_valid_reg;
  logic             s2_valid_reg;
  s1_t              s1_reg;
  s2_t              s2_reg;
  logic [TAG_W-1:0] s1_tag_reg;
  logic [TAG_W-1:0] s2_tag_reg;

  s1_t               s1_next;
  s2_t               s2_next;
  logic [PROD_W-1:0] tree_prod;
  logic [PROD_W-1:0] p;
  logic [1:0]        grant;
  logic              grant_id;
  logic              adv2;
  logic              can_accept;
  logic              accept;

  op_e             port_op    [2];
  logic            port_neg   [2];
  logic [XLEN-1:0] port_mag_a [2];
  logic [XLEN-1:0] port_mag_b [2];

  // Sign decode runs on both ports in parallel so the grant only has to pick a result.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      logic sa;
      logic sb;
      assign port_op[gi]    = op_e'(req_op[gi]);
      assign sa             = req_a[gi][XLEN-1] & ((port_op[gi] == OP_MULH) | (port_op[gi] == OP_MULHSU));
      assign sb             = req_b[gi][XLEN-1] & (port_op[gi] == OP_MULH);
      assign port_neg[gi]   = sa ^ sb;
      assign port_mag_a[gi] = magnitude(req_a[gi], sa);
      assign port_mag_b[gi] = magnitude(req_b[gi], sb);
    end
  endgenerate

  always_comb begin
    grant_id   = (req_valid == 2'b11) ? rr_ptr_reg : req_valid[1];
    grant      = '0;
    if (|req_valid) begin
      grant[grant_id] = 1'b1;
    end
    adv2       = !s2_valid_reg || resp_ready;
    can_accept = !s1_valid_reg || adv2;
    req_ready  = grant & {2{can_accept && !flush && !rst}};
    accept     = |(req_valid & req_ready);

    s1_next       = '0;
    s1_next.mag_a = port_mag_a[grant_id];
    s1_next.mag_b = port_mag_b[grant_id];
    s1_next.neg   = port_neg[grant_id];
    s1_next.op    = port_op[grant_id];
    s1_next.id    = grant_id;
  end

  mult32b_core u_core (
    .a    (s1_reg.mag_a),
    .b    (s1_reg.mag_b),
    .prod (tree_prod)
  );

  always_comb begin
    s2_next      = '0;
    s2_next.prod = tree_prod;
    s2_next.neg  = s1_reg.neg;
    s2_next.op   = s1_reg.op;
    s2_next.id   = s1_reg.id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg   <= 1'b0;
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      s1_reg       <= '0;
      s2_reg       <= '0;
      s1_tag_reg   <= '0;
      s2_tag_reg   <= '0;
    end else begin
      if (accept) begin
        rr_ptr_reg <= ~grant_id;
        s1_reg     <= s1_next;
        s1_tag_reg <= req_tag[grant_id];
      end
      if (flush) begin
        s1_valid_reg <= 1'b0;
        s2_valid_reg <= 1'b0;
      end else begin
        if (adv2) begin
          s2_valid_reg <= s1_valid_reg;
        end
        if (can_accept) begin
          s1_valid_reg <= accept;
        end
      end
      // S2 payload only moves when a real operation advances, keeping a stalled response stable.
      if (adv2 && s1_valid_reg) begin
        s2_reg     <= s2_next;
        s2_tag_reg <= s1_tag_reg;
      end
    end
  end

  always_comb begin
    p          = s2_reg.neg ? ((~s2_reg.prod) + PROD_W'(1)) : s2_reg.prod;
    resp_data  = (s2_reg.op == OP_MUL) ? p[XLEN-1:0] : p[PROD_W-1:XLEN];
    resp_valid = s2_valid_reg;
    resp_id    = s2_reg.id;
    resp_tag   = s2_tag_reg;
  end

endmodule

// File: tb/tb_mult32b_sched.sv
// Scenario bench for mult32b_sched: scoreboard of expected responses filled on accept,
// drained on response handshake, plus inline checks of latency, stalls, flush and reset.
module tb_mult32b_sched;

  localparam int TAG_W = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  flush = 1'b0;
  logic [1:0]            req_valid = '0;
  logic [1:0]            req_ready;
  logic [1:0][1:0]       req_op = '0;
  logic [1:0][31:0]      req_a = '0;
  logic [1:0][31:0]      req_b = '0;
  logic [1:0][TAG_W-1:0] req_tag = '0;
  logic                  resp_valid;
  logic                  resp_ready = 1'b1;
  logic                  resp_id;
  logic [TAG_W-1:0]      resp_tag;
  logic [31:0]           resp_data;

  typedef struct packed {
    logic             id;
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic rr_model = 1'b0;

  logic [1:0]  sg_op  [4] = '{2'd1, 2'd3, 2'd2, 2'd1};
  logic [31:0] sg_a   [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] sg_b   [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0002, 32'h8000_0000};
  logic [31:0] sg_exp [4] = '{32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h4000_0000};

  mult32b_sched #(.TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_tag    (req_tag),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_tag   (resp_tag),
    .resp_data  (resp_data)
  );

  always #5 clk = ~clk;

  // Reference result from sign/zero-extended 64-bit operands (independent of the magnitude scheme).
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] pr;
    ea = (op == 2'd1 || op == 2'd2) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (op == 2'd1) ? {{32{b[31]}}, b} : {32'b0, b};
    pr = ea * eb;
    return (op == 2'd0) ? pr[31:0] : pr[63:32];
  endfunction

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    logic exp_id;
    if (rst) begin
      sb_q.delete();
      rr_model = 1'b0;
    end else begin
      if (resp_valid && resp_ready && !flush) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected got id=%0d tag=%0h data=%h want no response", resp_id, resp_tag, resp_data);
        end else begin
          e = sb_q.pop_front();
          if ({resp_id, resp_tag, resp_data} !== e) begin
            n_err++;
            $display("FAIL sb_resp got id=%0d tag=%0h data=%h want id=%0d tag=%0h data=%h",
                     resp_id, resp_tag, resp_data, e.id, e.tag, e.data);
          end else begin
            $display("resp id=%0d tag=%0h data=%h ok", resp_id, resp_tag, resp_data);
          end
        end
      end
      if (flush) begin
        sb_q.delete();
      end else begin
        for (int p = 0; p < 2; p++) begin
          if (req_valid[p] && req_ready[p]) begin
            exp_id = (req_valid == 2'b11) ? rr_model : req_valid[1];
            n_cmp++;
            if (1'(p) !== exp_id) begin
              n_err++;
              $display("FAIL sb_grant got port %0d want port %0d", p, exp_id);
            end
            e.id   = 1'(p);
            e.tag  = req_tag[p];
            e.data = model(req_op[p], req_a[p], req_b[p]);
            sb_q.push_back(e);
            $display("req  id=%0d tag=%0h op=%0d a=%h b=%h", p, req_tag[p], req_op[p], req_a[p], req_b[p]);
            rr_model = ~1'(p);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int p, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag);
    logic got;
    got          = 1'b0;
    req_valid[p] = 1'b1;
    req_op[p]    = op;
    req_a[p]     = a;
    req_b[p]     = b;
    req_tag[p]   = tag;
    for (int k = 0; k < 20 && !got; k++) begin
      #1;
      got = req_ready[p];
      step();
    end
    req_valid[p] = 1'b0;
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL issue_timeout port %0d tag %0h got never-ready want accepted", p, tag);
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    req_valid  = 2'b11;
    resp_ready = 1'b1;
    step();
    step();
    n_cmp++;
    if (req_ready !== 2'b00) begin
      n_err++;
      $display("FAIL reset_req_ready got %b want 00", req_ready);
    end
    n_cmp++;
    if ({resp_valid, resp_id, resp_tag, resp_data} !== '0) begin
      n_err++;
      $display("FAIL reset_resp got v=%b id=%b tag=%h data=%h want all zero", resp_valid, resp_id, resp_tag, resp_data);
    end
    req_valid = 2'b00;
    rst       = 1'b0;
    step();
  endtask

  task automatic test_basic();
    issue(0, 2'd0, 32'd7, 32'd6, 4'h5);
    n_cmp++;
    if (resp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_early got resp_valid=%b want 0", resp_valid);
    end
    step();
    n_cmp++;
    if ({resp_valid, resp_id, resp_tag, resp_data} !== {1'b1, 1'b0, 4'h5, 32'h0000_002A}) begin
      n_err++;
      $display("FAIL basic_result got v=%b id=%b tag=%h data=%h want v=1 id=0 tag=5 data=0000002a",
               resp_valid, resp_id, resp_tag, resp_data);
    end
    step();
  endtask

  task automatic test_signed();
    for (int i = 0; i < 4; i++) begin
      issue(1, sg_op[i], sg_a[i], sg_b[i], 4'(i + 1));
      step();
      n_cmp++;
      if (resp_valid !== 1'b1 || resp_data !== sg_exp[i]) begin
        n_err++;
        $display("FAIL signed_%0d got v=%b data=%h want v=1 data=%h", i, resp_valid, resp_data, sg_exp[i]);
      end
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [1:0] prev;
    prev       = 2'b00;
    resp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req_valid  = 2'b11;
      req_op[0]  = 2'd0;
      req_a[0]   = 32'(i + 1);
      req_b[0]   = 32'd3;
      req_tag[0] = 4'(i);
      req_op[1]  = 2'd3;
      req_a[1]   = 32'hFFFF_FFFF - 32'(i);
      req_b[1]   = 32'(i + 2);
      req_tag[1] = 4'(8 + i);
      #1;
      n_cmp++;
      if (!(req_ready == 2'b01 || req_ready == 2'b10) || (i > 0 && req_ready == prev)) begin
        n_err++;
        $display("FAIL rr_grant_%0d got %b want one-hot and not %b", i, req_ready, prev);
      end
      if (i >= 2) begin
        n_cmp++;
        if (resp_valid !== 1'b1) begin
          n_err++;
          $display("FAIL rr_throughput_%0d got resp_valid=%b want 1", i, resp_valid);
        end
      end
      prev = req_ready;
      step();
    end
    req_valid = 2'b00;
    for (int k = 0; k < 4; k++) step();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL rr_drain got %0d pending want 0", sb_q.size());
    end
  endtask

  task automatic test_backpressure();
    logic [37:0] snap;
    logic        got;
    resp_ready = 1'b0;
    req_valid  = 2'b01;
    req_op[0]  = 2'd0;
    req_b[0]   = 32'd3;
    for (int t = 0; t < 2; t++) begin
      req_a[0]   = 32'(10 + t);
      req_tag[0] = 4'(t);
      #1;
      n_cmp++;
      if (req_ready[0] !== 1'b1) begin
        n_err++;
        $display("FAIL bp_accept_%0d got ready=%b want 1", t, req_ready[0]);
      end
      step();
    end
    req_a[0]   = 32'd12;
    req_tag[0] = 4'd2;
    #1;
    n_cmp++;
    if (req_ready[0] !== 1'b0) begin
      n_err++;
      $display("FAIL bp_full got ready=%b want 0", req_ready[0]);
    end
    snap = {resp_valid, resp_id, resp_tag, resp_data};
    n_cmp++;
    if (snap !== {1'b1, 1'b0, 4'h0, 32'd30}) begin
      n_err++;
      $display("FAIL bp_head got %h want %h", snap, {1'b1, 1'b0, 4'h0, 32'd30});
    end
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++;
      if ({resp_valid, resp_id, resp_tag, resp_data} !== snap || req_ready[0] !== 1'b0) begin
        n_err++;
        $display("FAIL bp_stall_%0d got %h ready=%b want %h ready=0", k,
                 {resp_valid, resp_id, resp_tag, resp_data}, req_ready[0], snap);
      end
    end
    resp_ready = 1'b1;
    got        = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      #1;
      got = req_ready[0];
      step();
    end
    req_valid = 2'b00;
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL bp_release got never-ready want accepted");
    end
    for (int k = 0; k < 4; k++) step();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL bp_drain got %0d pending want 0", sb_q.size());
    end
  endtask

  task automatic test_flush();
    resp_ready = 1'b0;
    issue(0, 2'd0, 32'd11, 32'd13, 4'h1);
    issue(1, 2'd3, 32'hDEAD_BEEF, 32'h1234_5678, 4'h2);
    flush      = 1'b1;
    resp_ready = 1'b1;
    req_valid  = 2'b01;
    req_op[0]  = 2'd0;
    req_a[0]   = 32'd9;
    req_b[0]   = 32'd9;
    req_tag[0] = 4'h9;
    #1;
    n_cmp++;
    if (req_ready !== 2'b00) begin
      n_err++;
      $display("FAIL flush_ready got %b want 00", req_ready);
    end
    step();
    flush     = 1'b0;
    req_valid = 2'b00;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (resp_valid !== 1'b0) begin
        n_err++;
        $display("FAIL flush_empty_%0d got resp_valid=%b want 0", k, resp_valid);
      end
      step();
    end
    issue(0, 2'd0, 32'd3, 32'd5, 4'h7);
    step();
    n_cmp++;
    if ({resp_valid, resp_tag, resp_data} !== {1'b1, 4'h7, 32'h0000_000F}) begin
      n_err++;
      $display("FAIL flush_after got v=%b tag=%h data=%h want v=1 tag=7 data=0000000f", resp_valid, resp_tag, resp_data);
    end
    step();
  endtask

  task automatic test_reset_midflight();
    resp_ready = 1'b0;
    issue(0, 2'd0, 32'd2, 32'd2, 4'h1);
    issue(0, 2'd0, 32'd4, 32'd4, 4'h2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if (resp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_valid got %b want 0", resp_valid);
    end
    req_valid  = 2'b11;
    req_op[0]  = 2'd3;
    req_a[0]   = 32'hFFFF_FFFF;
    req_b[0]   = 32'd2;
    req_tag[0] = 4'h3;
    req_op[1]  = 2'd0;
    req_a[1]   = 32'd5;
    req_b[1]   = 32'd5;
    req_tag[1] = 4'h4;
    resp_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_err++;
      $display("FAIL rst_mid_rrptr got ready=%b want 01", req_ready);
    end
    step();
    req_valid = 2'b00;
    step();
    n_cmp++;
    if ({resp_valid, resp_id, resp_tag, resp_data} !== {1'b1, 1'b0, 4'h3, 32'h0000_0001}) begin
      n_err++;
      $display("FAIL rst_mid_result got v=%b id=%b tag=%h data=%h want v=1 id=0 tag=3 data=00000001",
               resp_valid, resp_id, resp_tag, resp_data);
    end
    for (int k = 0; k < 3; k++) step();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL rst_mid_drain got %0d pending want 0", sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
